// File: rtl/if_id_pkg.sv
// if_id_pkg: shared field-width defaults and FSM state encoding for the IF/ID pipe
package if_id_pkg;
    localparam int OPC_W_D      = 4;
    localparam int REG_W_D      = 4;
    localparam int IMM_W_D      = 16;
    localparam int NOP_OPCODE_D = 0;
    typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SKID} state_t;
endpackage

// File: rtl/if_id_field_split.sv
// if_id_field_split: slices an instruction into opcode, WN, RN1, RN2 and immediate
module if_id_field_split #(
    parameter int INSTR_W = 32,
    parameter int OPC_W   = 4,
    parameter int REG_W   = 4,
    parameter int IMM_W   = 16
) (
    input  logic [INSTR_W-1:0] i_instr,
    output logic [OPC_W-1:0]   o_opc,
    output logic [REG_W-1:0]   o_wn,
    output logic [REG_W-1:0]   o_rn1,
    output logic [REG_W-1:0]   o_rn2,
    output logic [IMM_W-1:0]   o_imm
);
    assign o_opc = i_instr[INSTR_W-1 -: OPC_W];
    assign o_wn  = i_instr[INSTR_W-OPC_W-1 -: REG_W];
    assign o_rn1 = i_instr[INSTR_W-OPC_W-REG_W-1 -: REG_W];
    assign o_rn2 = i_instr[IMM_W+REG_W-1 -: REG_W];
    assign o_imm = i_instr[IMM_W-1:0];
endmodule

// File: rtl/if_id_pipe.sv
// if_id_pipe: IF/ID register with valid/ready, 2-entry skid buffer, flush and stall counter
module if_id_pipe
    import if_id_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int PC_W       = 32,
    parameter int OPC_W      = OPC_W_D,
    parameter int REG_W      = REG_W_D,
    parameter int IMM_W      = IMM_W_D,
    parameter int NOP_OPCODE = NOP_OPCODE_D,
    parameter int CNT_W      = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               InValid,
    output logic               InReady,
    input  logic [INSTR_W-1:0] Instruction,
    input  logic [PC_W-1:0]    UpdatedPC,
    input  logic               Flush,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [OPC_W-1:0]   IF_ID_OpCode,
    output logic [REG_W-1:0]   IF_ID_WN,
    output logic [REG_W-1:0]   IF_ID_RN1,
    output logic [REG_W-1:0]   IF_ID_RN2,
    output logic [IMM_W-1:0]   IF_ID_IMM,
    output logic [PC_W-1:0]    IF_ID_PC,
    output logic [CNT_W-1:0]   StallCount
);
    localparam int F_W = OPC_W + 3 * REG_W + IMM_W;
    localparam int E_W = F_W + PC_W;

    generate
        if (INSTR_W != F_W) begin : g_bad_width
            $fatal(1, "if_id_pipe: INSTR_W must equal OPC_W+3*REG_W+IMM_W");
        end
    endgenerate

    logic [OPC_W-1:0] w_opc;
    logic [REG_W-1:0] w_wn, w_rn1, w_rn2;
    logic [IMM_W-1:0] w_imm;
    logic [E_W-1:0]   w_in_ent, r_main, r_skid;
    logic [CNT_W-1:0] r_cnt;
    logic             w_in_fire, w_out_fire, w_ld_main, w_ld_skid, w_pop_skid;
    state_t           r_state, w_nxt;

    if_id_field_split #(
        .INSTR_W(INSTR_W), .OPC_W(OPC_W), .REG_W(REG_W), .IMM_W(IMM_W)
    ) u_split (
        .i_instr(Instruction), .o_opc(w_opc), .o_wn(w_wn),
        .o_rn1(w_rn1), .o_rn2(w_rn2), .o_imm(w_imm)
    );

    assign w_in_ent   = {w_opc, w_wn, w_rn1, w_rn2, w_imm, UpdatedPC};
    // Both handshake outputs decode the state flop only, so OutReady never reaches InReady
    assign OutValid   = r_state != S_EMPTY;
    assign InReady    = r_state != S_SKID;
    assign w_in_fire  = InValid & InReady;
    assign w_out_fire = OutValid & OutReady;
    assign w_ld_main  = !Flush & w_in_fire & (r_state == S_EMPTY | (r_state == S_FULL & w_out_fire));
    assign w_ld_skid  = !Flush & w_in_fire & r_state == S_FULL & !w_out_fire;
    assign w_pop_skid = !Flush & r_state == S_SKID & w_out_fire;
    assign {IF_ID_OpCode, IF_ID_WN, IF_ID_RN1, IF_ID_RN2, IF_ID_IMM, IF_ID_PC} = r_main;
    assign StallCount = r_cnt;

    always_comb begin
        w_nxt = Flush ? S_EMPTY :
                r_state == S_EMPTY ? (w_in_fire ? S_FULL : S_EMPTY) :
                r_state == S_FULL  ? ((w_in_fire & !w_out_fire) ? S_SKID :
                                      (w_out_fire & !w_in_fire) ? S_EMPTY : S_FULL) :
                (w_out_fire ? S_FULL : S_SKID);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_EMPTY;
            r_main  <= {OPC_W'(NOP_OPCODE), {(E_W-OPC_W){1'b0}}};
            r_skid  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_ld_main)
                r_main <= w_in_ent;
            else if (w_pop_skid)
                r_main <= r_skid;
            if (w_ld_skid)
                r_skid <= w_in_ent;
            if (OutValid & !OutReady & ~&r_cnt)
                r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_if_id_pipe.sv
// tb_if_id_pipe: randomized scoreboard bench for if_id_pipe against a queue-based model
module tb_if_id_pipe;
    typedef struct packed {
        logic [3:0]  opc;
        logic [3:0]  wn;
        logic [3:0]  rn1;
        logic [3:0]  rn2;
        logic [15:0] imm;
        logic [31:0] pc;
    } ent_t;

    logic        Clk = 0, Reset = 1, InValid = 0, Flush = 0, OutReady = 0;
    logic [31:0] Instruction = 0, UpdatedPC = 0;
    logic        InReady, OutValid, InReady2, OutValid2;
    logic [3:0]  OpCode, WN, RN1, RN2, OpCode2, WN2, RN12, RN22;
    logic [15:0] IMM, IMM2, StallCount;
    logic [31:0] PC, PC2;
    logic [1:0]  StallCount2;

    ent_t q[$];
    int   n_cmp = 0, n_bad = 0, stalls = 0;
    logic prev_rst = 1;

    always #5 Clk = ~Clk;

    if_id_pipe u_dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .Instruction(Instruction), .UpdatedPC(UpdatedPC), .Flush(Flush),
        .OutValid(OutValid), .OutReady(OutReady), .IF_ID_OpCode(OpCode),
        .IF_ID_WN(WN), .IF_ID_RN1(RN1), .IF_ID_RN2(RN2), .IF_ID_IMM(IMM),
        .IF_ID_PC(PC), .StallCount(StallCount)
    );

    if_id_pipe #(.CNT_W(2)) u_dut2 (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady2),
        .Instruction(Instruction), .UpdatedPC(UpdatedPC), .Flush(Flush),
        .OutValid(OutValid2), .OutReady(OutReady), .IF_ID_OpCode(OpCode2),
        .IF_ID_WN(WN2), .IF_ID_RN1(RN12), .IF_ID_RN2(RN22), .IF_ID_IMM(IMM2),
        .IF_ID_PC(PC2), .StallCount(StallCount2)
    );

    function automatic ent_t expect_of(input logic [31:0] ins, input logic [31:0] pc);
        ent_t e;
        e.opc = 4'(ins >> 28);
        e.wn  = 4'(ins >> 24);
        e.rn1 = 4'(ins >> 20);
        e.rn2 = 4'(ins >> 16);
        e.imm = 16'(ins);
        e.pc  = pc;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: the model is just an ordered queue of accepted instructions, capacity 2
    initial begin : monitor
        forever begin
            @(negedge Clk);
            if (Reset) begin
                q.delete();
                stalls = 0;
                prev_rst = 1;
            end else begin
                bit in_fire, out_fire;
                if (prev_rst) begin
                    chk("reset_fields", {OpCode, WN, RN1, RN2, IMM, PC}, 64'h0);
                    prev_rst = 0;
                end
                chk("out_valid", OutValid, q.size() > 0);
                chk("in_ready", InReady, q.size() < 2);
                chk("out_valid_c2", OutValid2, q.size() > 0);
                chk("stall_cnt", StallCount, stalls > 65535 ? 65535 : stalls);
                chk("stall_cnt_c2", StallCount2, stalls > 3 ? 3 : stalls);
                in_fire  = InValid && q.size() < 2;
                out_fire = q.size() > 0 && OutReady;
                if (q.size() > 0 && !OutReady)
                    stalls++;
                if (out_fire) begin
                    ent_t e;
                    e = q.pop_front();
                    chk("data", {OpCode, WN, RN1, RN2, IMM, PC}, e);
                end
                if (Flush)
                    q.delete();
                else if (in_fire)
                    q.push_back(expect_of(Instruction, UpdatedPC));
            end
        end
    end

    task automatic drive(input logic v, input logic r, input logic f,
                         input logic [31:0] ins, input logic [31:0] pc);
        InValid = v; OutReady = r; Flush = f; Instruction = ins; UpdatedPC = pc;
        @(posedge Clk);
        #1;
    endtask

    task automatic rnd(input logic v, input logic r, input logic f);
        drive(v, r, f, $urandom, $urandom);
    endtask

    initial begin : stim
        repeat (3) @(posedge Clk);
        #1 Reset = 0;
        drive(1, 1, 0, 32'h1234_ABCD, 32'd4);
        chk("first_valid", OutValid, 1);
        chk("first_fields", {OpCode, WN, RN1, RN2, IMM, PC}, {4'h1, 4'h2, 4'h3, 4'h4, 16'hABCD, 32'd4});
        rnd(0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, $urandom, 32'(i * 4 + 8));
            chk("stream_valid", OutValid, 1);
            chk("stream_ready", InReady, 1);
        end
        rnd(0, 1, 0);
        rnd(0, 1, 0);
        repeat (4) rnd(1, 0, 0);
        chk("stall_three", StallCount, 16'd3);
        chk("skid_not_ready", InReady, 0);
        repeat (3) rnd(0, 1, 0);
        repeat (2) rnd(1, 0, 0);
        rnd(1, 0, 1);
        chk("flush_valid", OutValid, 0);
        chk("flush_ready", InReady, 1);
        repeat (2) rnd(0, 1, 0);
        repeat (6) rnd(1, 0, 0);
        chk("sat_c2", StallCount2, 2'd3);
        chk("skid_before_reset", InReady, 0);
        Reset = 1;
        rnd(1, 0, 0);
        Reset = 0;
        chk("rst_valid", OutValid, 0);
        chk("rst_opcode", OpCode, 4'd0);
        chk("rst_stall", StallCount, 16'd0);
        chk("rst_ready", InReady, 1);
        for (int i = 0; i < 3000; i++)
            rnd($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        repeat (4) rnd(0, 1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
